gf2m_digit_serial_mul: RTL and testbench
========================================

// Module: gf2m_digit_serial_mul
// PURPOSE
//  Parametrised GF(2^M) multiplier: po = ai*bi mod (x^M + gi), polynomial basis, MSB-first
//  interleaved reduction, DIG bits of bi consumed per clock. Successor to the fixed 32-bit
//  systolic multiplier: generic width/digit size, valid/ready handshake, explicit FSM.
//  Sits between operand staging and downstream ECC/crypto datapath.
// PARAMETERS
//  M    32  field degree; width of ai, bi, gi, po (M >= 2)
//  DIG  4   bits of bi processed per cycle (1 <= DIG <= M); NCYC = ceil(M/DIG)
// PORTS
//  clk        in   1  clock, rising edge
//  rst        in   1  synchronous active-low reset
//  in_valid   in   1  operand set valid
//  in_ready   out  1  block can accept operands this cycle
//  ai         in   M  multiplicand
//  bi         in   M  multiplier (consumed MSB first)
//  gi         in   M  field polynomial, low coefficients g[M-1:0] (x^M implicit)
//  out_valid  out  1  po holds a finished product
//  out_ready  in   1  consumer accepts po
//  po         out  M  product
//  busy       out  1  high in S_RUN
// BEHAVIOUR
//  - Reset (rst==0 at clk edge): state=S_IDLE, po=0, out_valid=0, busy=0, counter=0. Reset has
//    priority over every other event; an op in progress is discarded, no output produced.
//  - FSM: S_IDLE -(in_valid)-> S_RUN -(cnt==NCYC-1)-> S_DONE -(out_ready)-> S_IDLE, or straight
//    to S_RUN if in_valid is high in that same cycle (back-to-back).
//  - in_ready = (state==S_IDLE) | (state==S_DONE & out_ready); combinational on out_ready.
//  - Accept edge: latch ai, gi, bi into internal regs; acc=0; cnt=0.
//  - Each S_RUN cycle runs DIG inner steps, bit index k from M-1-cnt*DIG downward:
//      acc = {acc[M-2:0],1'b0} ^ (acc[M-1] ? g : 0) ^ (b[k] ? a : 0)
//    Steps with k<0 (last digit when M%DIG!=0) are no-ops: acc unchanged.
//  - Latency: out_valid rises exactly NCYC cycles after the accept edge; po=acc registered.
//  - S_DONE: po and out_valid held stable until out_ready; po keeps its value after handshake
//    (out_valid drops) until the next result overwrites it.
//  - Input changes on ai/bi/gi after accept have no effect on the running op.
//  - in_valid while S_RUN: ignored (in_ready=0); source must hold it.
//  - gi need not be irreducible; result is the defined reduction arithmetic regardless.
// CONFIGURATION
//  GF2M_MUL_ACC_EN defined: extra input port ci [M], latched at accept edge;
//    po = (ai*bi mod g) ^ ci (GF multiply-accumulate), latency unchanged.
//  GF2M_MUL_ACC_EN undefined: no ci port, po = ai*bi mod g.
// TESTING (M=8, DIG=2, gi=8'h1B unless stated)
//  1. ai=8'h57, bi=8'h83 -> out_valid 4 cycles after accept, po=8'hC1.
//  2. ai=8'h57, bi=8'h13 then ai=8'hA5, bi=8'h01 back-to-back with out_ready=1 ->
//     po=8'hFE then po=8'hA5, no idle cycle between ops.
//  3. M=8, DIG=3 (NCYC=3): ai=8'h57, bi=8'h83 -> po=8'hC1 after 3 cycles; bi=0 -> po=0.
//  4. out_ready=0 for 5 cycles after out_valid -> po, out_valid stable; in_ready=0; new in_valid
//     ignored until out_ready=1.
//  5. rst=0 at 2nd S_RUN cycle -> next cycle out_valid=0, po=0, in_ready=1; no stale result.
//  6. GF2M_MUL_ACC_EN, ci=8'hFF, ai=8'h57, bi=8'h83 -> po=8'h3E; M=32, DIG=4 random vs model.

Source files
------------

// File: rtl/gf2m_digit_serial_mul.sv
// Digit-serial GF(2^M) multiplier, MSB-first interleaved reduction, DIG bits of bi per clock.
// Optional macro GF2M_MUL_ACC_EN adds a ci input and returns (ai*bi mod g) ^ ci.
module gf2m_digit_serial_mul #(
  parameter int M   = 32,
  parameter int DIG = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [M-1:0] ai,
  input  logic [M-1:0] bi,
  input  logic [M-1:0] gi,
`ifdef GF2M_MUL_ACC_EN
  input  logic [M-1:0] ci,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [M-1:0] po,
  output logic         busy
);

  localparam int NCYC = (M + DIG - 1) / DIG;
  localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NCYC - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [M-1:0]  r_a;
  logic [M-1:0]  r_b;
  logic [M-1:0]  r_g;
  logic [M-1:0]  r_acc;
  logic [M-1:0]  r_po;
  logic          r_out_valid;
  logic          r_busy;
  logic [M-1:0]  r_c;

  logic          w_accept;
  logic          w_last;
  logic [M-1:0]  w_acc_next;
  logic [M-1:0]  w_result;

  // Steps past bit 0 (short final digit) leave the accumulator untouched.
  function automatic logic [M-1:0] digit_step(input logic [M-1:0] acc, input logic [M-1:0] a,
                                              input logic [DIG-1:0] bt, input logic [M-1:0] g,
                                              input logic [CW-1:0] cnt);
    logic [M-1:0] x;
    int base;
    x    = acc;
    base = int'(cnt) * DIG;
    for (int j = 0; j < DIG; j++) begin
      if (base + j < M) begin
        x = {x[M-2:0], 1'b0} ^ (x[M-1] ? g : {M{1'b0}}) ^ (bt[DIG-1-j] ? a : {M{1'b0}});
      end else begin
        x = x;
      end
    end
    return x;
  endfunction

  assign in_ready   = (r_state == S_IDLE) | ((r_state == S_DONE) & out_ready);
  assign w_accept   = in_valid & in_ready;
  assign w_last     = (r_state == S_RUN) && (r_cnt == CNT_LAST);
  assign w_acc_next = digit_step(r_acc, r_a, r_b[M-1 -: DIG], r_g, r_cnt);

`ifdef GF2M_MUL_ACC_EN
  assign w_result = w_acc_next ^ r_c;
`else
  assign w_result = w_acc_next;
`endif

  // Operand capture and per-digit accumulation; bi is shifted so its next digit sits at the top.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_a   <= {M{1'b0}};
      r_b   <= {M{1'b0}};
      r_g   <= {M{1'b0}};
      r_c   <= {M{1'b0}};
      r_acc <= {M{1'b0}};
      r_cnt <= {CW{1'b0}};
    end else if (w_accept) begin
      r_a   <= ai;
      r_b   <= bi;
      r_g   <= gi;
`ifdef GF2M_MUL_ACC_EN
      r_c   <= ci;
`else
      r_c   <= {M{1'b0}};
`endif
      r_acc <= {M{1'b0}};
      r_cnt <= {CW{1'b0}};
    end else if (r_state == S_RUN) begin
      r_acc <= w_acc_next;
      r_b   <= r_b << DIG;
      r_cnt <= r_cnt + CW'(1);
    end else begin
      r_acc <= r_acc;
      r_b   <= r_b;
      r_cnt <= r_cnt;
    end
  end

  // Control FSM and registered result/handshake outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_po        <= {M{1'b0}};
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state <= S_RUN;
            r_busy  <= 1'b1;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          if (w_last) begin
            r_state     <= S_DONE;
            r_po        <= w_result;
            r_out_valid <= 1'b1;
            r_busy      <= 1'b0;
          end else begin
            r_state <= S_RUN;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            if (w_accept) begin
              r_state <= S_RUN;
              r_busy  <= 1'b1;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_state <= S_DONE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign po        = r_po;
  assign busy      = r_busy;

endmodule

// File: tb/tb_gf2m_digit_serial_mul.sv
// Bench for gf2m_digit_serial_mul: three instances (M/DIG = 8/2, 8/3, 32/4), each with a
// scoreboard monitor built on plain polynomial multiply-then-reduce arithmetic.
module tb_gf2m_digit_serial_mul;

  localparam int NI = 3;
`ifdef GF2M_MUL_ACC_EN
  localparam bit ACC_EN = 1'b1;
`else
  localparam bit ACC_EN = 1'b0;
`endif

  function automatic int cfg_m(input int i);
    return (i == 2) ? 32 : 8;
  endfunction
  function automatic int cfg_d(input int i);
    return (i == 0) ? 2 : ((i == 1) ? 3 : 4);
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;
  logic        in_valid_v [NI];
  logic        out_ready_v[NI];
  logic        in_ready_v [NI];
  logic        out_valid_v[NI];
  logic [31:0] ai_v[NI], bi_v[NI], gi_v[NI], ci_v[NI], po_v[NI];
  int          pend_v[NI];
  bit          rnd_en[NI];

  always @(posedge clk) cyc <= cyc + 1;

  // Carry-less product followed by long division by x^m + g.
  function automatic logic [31:0] gf_model(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] g, input int m);
    logic [63:0] p;
    logic [63:0] poly;
    p = 64'd0;
    for (int i = 0; i < m; i++) if (b[i]) p ^= (64'(a) << i);
    poly = (64'd1 << m) | 64'(g);
    for (int i = 2 * m - 2; i >= m; i--) if (p[i]) p ^= (poly << (i - m));
    return p[31:0];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  for (genvar gk = 0; gk < NI; gk++) begin : g_dut
    localparam int M  = cfg_m(gk);
    localparam int D  = cfg_d(gk);
    localparam int NC = (M + D - 1) / D;
    logic [M-1:0] w_po;
    logic         w_ir, w_ov, w_busy;

    gf2m_digit_serial_mul #(.M(M), .DIG(D)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid_v[gk]), .in_ready(w_ir),
      .ai(ai_v[gk][M-1:0]), .bi(bi_v[gk][M-1:0]), .gi(gi_v[gk][M-1:0]),
`ifdef GF2M_MUL_ACC_EN
      .ci(ci_v[gk][M-1:0]),
`endif
      .out_valid(w_ov), .out_ready(out_ready_v[gk]), .po(w_po), .busy(w_busy));

    assign in_ready_v[gk]  = w_ir;
    assign out_valid_v[gk] = w_ov;
    assign po_v[gk]        = 32'(w_po);

    logic [31:0]  exp_q[$];
    int           acc_q[$];
    bit           prev_ov = 1'b0, prev_hs = 1'b0, was_rst = 1'b1;
    logic [M-1:0] prev_po = '0;

    always @(negedge clk) begin : mon
      bit          new_res, bexp;
      logic [31:0] e;
      if (was_rst) begin
        chk($sformatf("i%0d rst ov", gk), 32'(w_ov), 32'd0);
        chk($sformatf("i%0d rst po", gk), 32'(w_po), 32'd0);
        chk($sformatf("i%0d rst busy", gk), 32'(w_busy), 32'd0);
        chk($sformatf("i%0d rst ready", gk), 32'(w_ir), 32'd1);
        exp_q.delete();
        acc_q.delete();
      end else begin
        new_res = (w_ov === 1'b1) && (!prev_ov || prev_hs);
        if (prev_ov && !prev_hs) begin
          chk($sformatf("i%0d hold ov", gk), 32'(w_ov), 32'd1);
          chk($sformatf("i%0d hold po", gk), 32'(w_po), 32'(prev_po));
        end
        if (prev_hs && !new_res) chk($sformatf("i%0d keep po", gk), 32'(w_po), 32'(prev_po));
        if (new_res) begin
          if (exp_q.size() == 0) begin
            chk($sformatf("i%0d unexpected result", gk), 32'(w_ov), 32'd0);
          end else begin
            chk($sformatf("i%0d po", gk), 32'(w_po), exp_q[0]);
            chk($sformatf("i%0d latency", gk), 32'(cyc - acc_q[0]), 32'(NC));
            void'(exp_q.pop_front());
            void'(acc_q.pop_front());
          end
        end
        bexp = (acc_q.size() > 0) && (cyc >= acc_q[acc_q.size()-1]) &&
               (cyc < acc_q[acc_q.size()-1] + NC);
        chk($sformatf("i%0d busy", gk), 32'(w_busy), 32'(bexp));
        chk($sformatf("i%0d in_ready", gk), 32'(w_ir),
            32'(!bexp && (!w_ov || out_ready_v[gk])));
      end
      prev_ov = (w_ov === 1'b1);
      prev_hs = (w_ov === 1'b1) && out_ready_v[gk] && rst;
      prev_po = w_po;
      if (rst && in_valid_v[gk] && w_ir) begin
        e = gf_model(32'(ai_v[gk][M-1:0]), 32'(bi_v[gk][M-1:0]), 32'(gi_v[gk][M-1:0]), M);
        if (ACC_EN) e = e ^ 32'(ci_v[gk][M-1:0]);
        exp_q.push_back(e);
        acc_q.push_back(cyc + 1);
      end
      was_rst = (rst == 1'b0);
      pend_v[gk] = exp_q.size();
    end
  end

  // Randomised consumer back-pressure.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++) if (rnd_en[i]) out_ready_v[i] = 1'($urandom_range(0, 1));
    end
  end

  task automatic do_op(input int i, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] g, input logic [31:0] c, output int acc_e);
    bit done;
    done = 1'b0;
    acc_e = -1;
    ai_v[i] = a; bi_v[i] = b; gi_v[i] = g; ci_v[i] = c;
    in_valid_v[i] = 1'b1;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      if (in_ready_v[i] === 1'b1) begin
        done  = 1'b1;
        acc_e = cyc + 1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      tests++; fails++;
      $display("FAIL accept timeout: inst %0d got no in_ready, required in_ready=1", i);
    end
    in_valid_v[i] = 1'b0;
    ai_v[i] = $urandom; bi_v[i] = $urandom; gi_v[i] = $urandom; ci_v[i] = $urandom;
  endtask

  task automatic wait_res(input int i, output int c);
    c = -1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (out_valid_v[i] === 1'b1) begin
        c = cyc;
        break;
      end
    end
    if (c < 0) begin
      tests++; fails++;
      $display("FAIL result timeout: inst %0d got out_valid=0, required out_valid=1", i);
    end
  endtask

  initial begin
    int ae, c, c2;
    rst = 1'b0;
    for (int i = 0; i < NI; i++) begin
      in_valid_v[i] = 1'b0; out_ready_v[i] = 1'b1; rnd_en[i] = 1'b0;
      ai_v[i] = 32'd0; bi_v[i] = 32'd0; gi_v[i] = 32'd0; ci_v[i] = 32'd0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;

    chk("model 57*83", gf_model(32'h57, 32'h83, 32'h1B, 8), 32'hC1);
    chk("model 57*13", gf_model(32'h57, 32'h13, 32'h1B, 8), 32'hFE);
    chk("model 02*80", gf_model(32'h02, 32'h80, 32'h1B, 8), 32'h1B);

    // basic product and latency
    do_op(0, 32'h57, 32'h83, 32'h1B, 32'h0, ae);
    wait_res(0, c);
    chk("t1 po", po_v[0], 32'hC1);
    chk("t1 latency", 32'(c - ae), 32'd4);
    @(posedge clk); #1;

    // back-to-back with no idle cycle
    do_op(0, 32'h57, 32'h13, 32'h1B, 32'h0, ae);
    ai_v[0] = 32'hA5; bi_v[0] = 32'h01; gi_v[0] = 32'h1B; ci_v[0] = 32'h0;
    in_valid_v[0] = 1'b1;
    wait_res(0, c);
    chk("t2 po first", po_v[0], 32'hFE);
    chk("t2 ready in done", 32'(in_ready_v[0]), 32'd1);
    @(posedge clk); #1;
    in_valid_v[0] = 1'b0;
    wait_res(0, c2);
    chk("t2 po second", po_v[0], 32'hA5);
    chk("t2 b2b spacing", 32'(c2 - c), 32'd5);
    @(posedge clk); #1;

    // consumer stall: result held, new request ignored
    out_ready_v[0] = 1'b0;
    do_op(0, 32'h57, 32'h83, 32'h1B, 32'h0, ae);
    wait_res(0, c);
    @(posedge clk); #1;
    ai_v[0] = 32'h02; bi_v[0] = 32'h80; gi_v[0] = 32'h1B; ci_v[0] = 32'h0;
    in_valid_v[0] = 1'b1;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk("t4 ov stable", 32'(out_valid_v[0]), 32'd1);
      chk("t4 po stable", po_v[0], 32'hC1);
      chk("t4 in_ready", 32'(in_ready_v[0]), 32'd0);
    end
    @(posedge clk); #1;
    out_ready_v[0] = 1'b1;
    @(posedge clk); #1;
    in_valid_v[0] = 1'b0;
    wait_res(0, c);
    chk("t4 po next", po_v[0], 32'h1B);
    @(posedge clk); #1;

    // reset in the second run cycle discards the op
    do_op(0, 32'h57, 32'h83, 32'h1B, 32'h0, ae);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("t5 ov", 32'(out_valid_v[0]), 32'd0);
    chk("t5 po", po_v[0], 32'h0);
    chk("t5 in_ready", 32'(in_ready_v[0]), 32'd1);
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      chk("t5 no stale", 32'(out_valid_v[0]), 32'd0);
    end
    @(posedge clk); #1;

    // DIG=3: short final digit
    do_op(1, 32'h57, 32'h83, 32'h1B, 32'h0, ae);
    wait_res(1, c);
    chk("t3 po", po_v[1], 32'hC1);
    chk("t3 latency", 32'(c - ae), 32'd3);
    @(posedge clk); #1;
    do_op(1, 32'h57, 32'h00, 32'h1B, 32'h0, ae);
    wait_res(1, c);
    chk("t3 zero", po_v[1], 32'h0);
    @(posedge clk); #1;

`ifdef GF2M_MUL_ACC_EN
    do_op(0, 32'h57, 32'h83, 32'h1B, 32'hFF, ae);
    wait_res(0, c);
    chk("t6 mac po", po_v[0], 32'h3E);
    @(posedge clk); #1;
`endif

    // random operands and back-pressure
    rnd_en[0] = 1'b1;
    for (int n = 0; n < 25; n++)
      do_op(0, $urandom & 32'hFF, $urandom & 32'hFF, $urandom & 32'hFF, $urandom & 32'hFF, ae);
    rnd_en[0] = 1'b0;
    rnd_en[2] = 1'b1;
    for (int n = 0; n < 30; n++) do_op(2, $urandom, $urandom, $urandom, $urandom, ae);
    rnd_en[2] = 1'b0;
    @(posedge clk); #2;
    for (int i = 0; i < NI; i++) out_ready_v[i] = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < NI; i++) chk($sformatf("drain i%0d", i), 32'(pend_v[i]), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
